// File: rtl/uart_tx_feeder_if.sv
// Write-side and transmitter-side signals of the UART transmit feeder.
interface uart_tx_feeder_if #(
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          clr;
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          word_en;
   logic [63:0]   word_data;
   logic          tx_busy;
   logic [7:0]    tx_data;
   logic          tx_start;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          overflow;
   logic          tx_err;

   // Producer / transmitter-model side
   modport master (
      output clr, wr_en, wr_data, word_en, word_data, tx_busy,
      input  tx_data, tx_start, count, full, empty, overflow, tx_err
   );

   // Feeder side
   modport slave (
      input  clr, wr_en, wr_data, word_en, word_data, tx_busy,
      output tx_data, tx_start, count, full, empty, overflow, tx_err
   );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte/word FIFO that feeds a UART transmitter one byte per busy frame,
// with a start-to-busy timeout and sticky overflow / error flags.
module uart_tx_feeder #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned TIMEOUT = 4096
) (
   input logic            clk,
   input logic            rst_n,
   uart_tx_feeder_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] WORD_MAX = CW'(DEPTH - 8);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TMR_MAX  = {TW{1'b1}};

   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

   state_t        state_q, state_d;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    tx_data_q;
   logic          tx_start_q, tx_start_d;
   logic          overflow_q, tx_err_q;
   logic          pop_c, tmo_c, byte_ok_c, word_ok_c, reject_c;

   assign bus.tx_data  = tx_data_q;
   assign bus.tx_start = tx_start_q;
   assign bus.count    = count_q;
   assign bus.full     = (count_q == DEPTH_C);
   assign bus.empty    = (count_q == '0);
   assign bus.overflow = overflow_q;
   assign bus.tx_err   = tx_err_q;

   // Write acceptance: word wins over byte, a dual request always drops the byte
   always_comb begin
      byte_ok_c = 1'b0;
      word_ok_c = 1'b0;
      reject_c  = 1'b0;
      if (bus.word_en) begin
         word_ok_c = (count_q <= WORD_MAX);
         reject_c  = !word_ok_c || bus.wr_en;
      end else if (bus.wr_en) begin
         byte_ok_c = (count_q != DEPTH_C);
         reject_c  = !byte_ok_c;
      end
   end

   // Next pointer and occupancy from accepted writes and the FSM pop
   always_comb begin
      wptr_d  = wptr_q;
      count_d = count_q;
      if (word_ok_c) begin
         wptr_d  = wptr_q + AW'(8);
         count_d = count_q + CW'(8);
      end else if (byte_ok_c) begin
         wptr_d  = wptr_q + AW'(1);
         count_d = count_q + CW'(1);
      end
      if (pop_c) begin
         count_d = count_d - CW'(1);
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else if (bus.clr) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Transmit sequencing: pop, pulse start, wait for busy (with timeout), wait for idle
   always_comb begin
      state_d    = state_q;
      tx_start_d = 1'b0;
      timer_d    = timer_q;
      pop_c      = 1'b0;
      tmo_c      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop_c      = 1'b1;
               tx_start_d = 1'b1;
               timer_d    = '0;
               state_d    = START;
            end
         end
         START: begin
            // timer is zero for the whole START cycle and counts from here
            timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + TW'(1);
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (bus.tx_busy) begin
               state_d = WAIT_DONE;
            end else if (timer_q == TMO_LAST) begin
               tmo_c   = 1'b1;
               state_d = IDLE;
            end else begin
               timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + TW'(1);
            end
         end
         WAIT_DONE: begin
            if (!bus.tx_busy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pointers, occupancy, timer, output byte and sticky flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         timer_q    <= '0;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
         overflow_q <= 1'b0;
         tx_err_q   <= 1'b0;
      end else if (bus.clr) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         timer_q    <= '0;
         tx_start_q <= 1'b0;
         overflow_q <= 1'b0;
         tx_err_q   <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         count_q    <= count_d;
         timer_q    <= timer_d;
         tx_start_q <= tx_start_d;
         overflow_q <= overflow_q | reject_c;
         tx_err_q   <= tx_err_q | tmo_c;
         if (pop_c) begin
            rptr_q    <= rptr_q + AW'(1);
            tx_data_q <= mem[rptr_q];
         end
      end
   end

   // Byte storage; a word lands in eight consecutive slots, low byte first
   always_ff @(posedge clk) begin
      if (!bus.clr) begin
         if (word_ok_c) begin
            for (int i = 0; i < 8; i++) begin
               mem[wptr_q + AW'(i)] <= bus.word_data[8*i +: 8];
            end
         end else if (byte_ok_c) begin
            mem[wptr_q] <= bus.wr_data;
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: transmitter model, byte scoreboard, scenario tasks.
module tb_uart_tx_feeder;
   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 20;
   localparam int MODE_NORM = 0;
   localparam int MODE_LOW  = 1;
   localparam int MODE_HIGH = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   n_start = 0;
   logic [7:0] exp_q[$];

   int bfm_mode  = MODE_NORM;
   int bfm_delay = 0;
   int bfm_len   = 10;
   int wait_c    = 0;
   int bcnt      = 0;
   int done_cnt  = 0;

   uart_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

   uart_tx_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Transmitter model: busy rises bfm_delay cycles after the start cycle + 1, lasts bfm_len cycles
   always @(posedge clk) begin
      #1;
      if (bfm_mode == MODE_HIGH) begin
         bus.tx_busy = 1'b1;
         wait_c = 0;
      end else if (bfm_mode == MODE_LOW) begin
         bus.tx_busy = 1'b0;
         wait_c = 0;
      end else begin
         if (bus.tx_busy) begin
            if (bcnt == 0) begin
               bus.tx_busy = 1'b0;
               done_cnt++;
            end else begin
               bcnt--;
            end
         end else if (wait_c > 0) begin
            wait_c--;
            if (wait_c == 0) begin
               bus.tx_busy = 1'b1;
               bcnt = bfm_len - 1;
            end
         end
         if (bus.tx_start) begin
            total++;
            if (wait_c > 0 || bus.tx_busy) begin
               bad++;
               $display("FAIL start_during_frame busy=%0b pending=%0d required idle line", bus.tx_busy, wait_c);
            end
            wait_c = bfm_delay + 1;
         end
      end
   end

   // Scoreboard: every start must present the next expected byte
   always @(negedge clk) begin
      if (rst_n && bus.tx_start) begin
         n_start++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_start tx_data=%h required no start", bus.tx_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (bus.tx_data !== e) begin
               bad++;
               $display("FAIL tx_byte got=%h required=%h", bus.tx_data, e);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic drive_byte(input logic [7:0] b);
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_data = b; bus.word_en = 1'b0;
   endtask

   task automatic drive_word(input logic [63:0] w);
      @(negedge clk);
      bus.wr_en = 1'b0; bus.word_en = 1'b1; bus.word_data = w;
   endtask

   task automatic drive_idle();
      @(negedge clk);
      bus.wr_en = 1'b0; bus.word_en = 1'b0; bus.clr = 1'b0;
   endtask

   task automatic push_word(input logic [63:0] w);
      for (int i = 0; i < 8; i++) exp_q.push_back(w[8*i +: 8]);
   endtask

   task automatic set_mode(input int m);
      bfm_mode = m;
      bcnt = 0;
   endtask

   task automatic do_clr();
      @(negedge clk);
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      exp_q.delete();
   endtask

   task automatic wait_drain(input string name, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0 && bus.count == '0 && !bus.tx_busy && wait_c == 0 && !bus.tx_start) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s_drain got pending=%0d count=%0d required drained within %0d", name, exp_q.size(), bus.count, budget);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total += 7;
      if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h required=00", bus.tx_data); end
      if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL rst_tx_start got=%b required=0", bus.tx_start); end
      if (bus.count !== '0)      begin bad++; $display("FAIL rst_count got=%0d required=0", bus.count); end
      if (bus.empty !== 1'b1)    begin bad++; $display("FAIL rst_empty got=%b required=1", bus.empty); end
      if (bus.full !== 1'b0)     begin bad++; $display("FAIL rst_full got=%b required=0", bus.full); end
      if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b required=0", bus.overflow); end
      if (bus.tx_err !== 1'b0)   begin bad++; $display("FAIL rst_tx_err got=%b required=0", bus.tx_err); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_byte();
      int s0 = n_start;
      bfm_delay = 0; bfm_len = 10;
      drive_byte(8'hA5); exp_q.push_back(8'hA5);
      drive_idle();                       // cycle N+1
      total += 2;
      if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL single_early_start got=%b required=0", bus.tx_start); end
      if (bus.count !== 5'd1)    begin bad++; $display("FAIL single_count got=%0d required=1", bus.count); end
      @(negedge clk);                     // cycle N+2
      total += 2;
      if (bus.tx_start !== 1'b1) begin bad++; $display("FAIL single_latency got=%b required=1", bus.tx_start); end
      if (bus.tx_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h required=a5", bus.tx_data); end
      @(negedge clk);                     // cycle N+3
      total += 2;
      if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL single_pulse_width got=%b required=0", bus.tx_start); end
      if (bus.tx_busy !== 1'b1)  begin bad++; $display("FAIL single_busy got=%b required=1", bus.tx_busy); end
      wait_drain("single", 100);
      total += 3;
      if (n_start - s0 != 1)     begin bad++; $display("FAIL single_pulses got=%0d required=1", n_start - s0); end
      if (bus.count !== '0)      begin bad++; $display("FAIL single_count_end got=%0d required=0", bus.count); end
      if (bus.tx_data !== 8'hA5) begin bad++; $display("FAIL single_hold got=%h required=a5", bus.tx_data); end
   endtask

   task automatic test_word();
      int s0 = n_start;
      bfm_delay = 1; bfm_len = 3;
      drive_word(64'h1122334455667788); push_word(64'h1122334455667788);
      drive_idle();
      total++;
      if (bus.count !== 5'd8) begin bad++; $display("FAIL word_count got=%0d required=8", bus.count); end
      wait_drain("word", 300);
      total += 2;
      if (n_start - s0 != 8)     begin bad++; $display("FAIL word_pulses got=%0d required=8", n_start - s0); end
      if (bus.overflow !== 1'b0) begin bad++; $display("FAIL word_overflow got=%b required=0", bus.overflow); end
   endtask

   task automatic test_both_en();
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_data = 8'hEE; bus.word_en = 1'b1; bus.word_data = 64'h0807060504030201;
      push_word(64'h0807060504030201);
      drive_idle();
      total += 2;
      if (bus.count !== 5'd8)    begin bad++; $display("FAIL both_count got=%0d required=8", bus.count); end
      if (bus.overflow !== 1'b1) begin bad++; $display("FAIL both_overflow got=%b required=1", bus.overflow); end
      wait_drain("both", 300);
   endtask

   task automatic test_timeout();
      bit got = 1'b0;
      set_mode(MODE_LOW);
      drive_byte(8'h31); exp_q.push_back(8'h31);
      drive_byte(8'h32); exp_q.push_back(8'h32);
      drive_idle();
      for (int i = 0; i < 10; i++) begin
         if (bus.tx_start) begin got = 1'b1; break; end
         @(negedge clk);
      end
      total++;
      if (!got) begin bad++; $display("FAIL tmo_first_start got=0 required=1"); end
      repeat (TIMEOUT - 1) @(negedge clk);
      total++;
      if (bus.tx_err !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b required=0", bus.tx_err); end
      @(negedge clk);
      total++;
      if (bus.tx_err !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b required=1", bus.tx_err); end
      @(negedge clk);
      total++;
      if (bus.tx_start !== 1'b1) begin bad++; $display("FAIL tmo_next_attempt got=%b required=1", bus.tx_start); end
      repeat (TIMEOUT + 2) @(negedge clk);
      total += 2;
      if (bus.count !== '0)    begin bad++; $display("FAIL tmo_count got=%0d required=0", bus.count); end
      if (bus.tx_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b required=1", bus.tx_err); end
      set_mode(MODE_NORM);
   endtask

   task automatic test_clr();
      int s0;
      set_mode(MODE_HIGH);
      drive_byte(8'hC3); exp_q.push_back(8'hC3);
      repeat (3) drive_idle();
      drive_byte(8'h01); drive_byte(8'h02); drive_byte(8'h03);
      @(negedge clk);
      bus.clr = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h5A;
      drive_idle();
      exp_q.delete();
      total += 6;
      if (bus.count !== '0)      begin bad++; $display("FAIL clr_count got=%0d required=0", bus.count); end
      if (bus.empty !== 1'b1)    begin bad++; $display("FAIL clr_empty got=%b required=1", bus.empty); end
      if (bus.overflow !== 1'b0) begin bad++; $display("FAIL clr_overflow got=%b required=0", bus.overflow); end
      if (bus.tx_err !== 1'b0)   begin bad++; $display("FAIL clr_tx_err got=%b required=0", bus.tx_err); end
      if (bus.tx_data !== 8'hC3) begin bad++; $display("FAIL clr_tx_data got=%h required=c3", bus.tx_data); end
      if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL clr_tx_start got=%b required=0", bus.tx_start); end
      set_mode(MODE_NORM);
      s0 = n_start;
      repeat (10) @(negedge clk);
      total++;
      if (n_start != s0) begin bad++; $display("FAIL clr_no_start got=%0d required=0", n_start - s0); end
   endtask

   task automatic test_full();
      set_mode(MODE_HIGH);
      drive_byte(8'h00); exp_q.push_back(8'h00);
      repeat (3) drive_idle();
      for (int i = 0; i < DEPTH; i++) begin
         drive_byte(8'(8'h10 + i)); exp_q.push_back(8'(8'h10 + i));
      end
      drive_idle();
      total += 4;
      if (bus.count !== 5'(DEPTH)) begin bad++; $display("FAIL full_count got=%0d required=%0d", bus.count, DEPTH); end
      if (bus.full !== 1'b1)       begin bad++; $display("FAIL full_flag got=%b required=1", bus.full); end
      if (bus.empty !== 1'b0)      begin bad++; $display("FAIL full_empty got=%b required=0", bus.empty); end
      if (bus.overflow !== 1'b0)   begin bad++; $display("FAIL full_early_ovf got=%b required=0", bus.overflow); end
      drive_byte(8'hEE);
      drive_idle();
      total += 2;
      if (bus.overflow !== 1'b1)   begin bad++; $display("FAIL full_overflow got=%b required=1", bus.overflow); end
      if (bus.count !== 5'(DEPTH)) begin bad++; $display("FAIL full_count_after got=%0d required=%0d", bus.count, DEPTH); end
      bfm_delay = 0; bfm_len = 2;
      set_mode(MODE_NORM);
      wait_drain("full", 500);
      total++;
      if (bus.overflow !== 1'b1) begin bad++; $display("FAIL full_sticky got=%b required=1", bus.overflow); end
      do_clr();
   endtask

   task automatic test_word_reject();
      set_mode(MODE_HIGH);
      drive_byte(8'h01); exp_q.push_back(8'h01);
      repeat (3) drive_idle();
      for (int i = 0; i < DEPTH - 7; i++) begin
         drive_byte(8'(8'h20 + i)); exp_q.push_back(8'(8'h20 + i));
      end
      drive_word(64'hDEADBEEFCAFEF00D);
      drive_idle();
      total += 2;
      if (bus.count !== 5'(DEPTH - 7)) begin bad++; $display("FAIL wrej_count got=%0d required=%0d", bus.count, DEPTH - 7); end
      if (bus.overflow !== 1'b1)       begin bad++; $display("FAIL wrej_overflow got=%b required=1", bus.overflow); end
      set_mode(MODE_NORM);
      wait_drain("wrej", 500);
      do_clr();
      // one slot fewer queued: the word fits exactly
      set_mode(MODE_HIGH);
      drive_byte(8'h02); exp_q.push_back(8'h02);
      repeat (3) drive_idle();
      for (int i = 0; i < DEPTH - 8; i++) begin
         drive_byte(8'(8'h40 + i)); exp_q.push_back(8'(8'h40 + i));
      end
      drive_word(64'hF7E6D5C4B3A29180); push_word(64'hF7E6D5C4B3A29180);
      drive_idle();
      total += 3;
      if (bus.count !== 5'(DEPTH)) begin bad++; $display("FAIL wacc_count got=%0d required=%0d", bus.count, DEPTH); end
      if (bus.full !== 1'b1)       begin bad++; $display("FAIL wacc_full got=%b required=1", bus.full); end
      if (bus.overflow !== 1'b0)   begin bad++; $display("FAIL wacc_overflow got=%b required=0", bus.overflow); end
      set_mode(MODE_NORM);
      wait_drain("wacc", 500);
   endtask

   task automatic test_back_to_back();
      int acc = 0, starts = 0, s0, d0;
      do_clr();
      set_mode(MODE_NORM);
      s0 = n_start;
      d0 = done_cnt;
      for (int c = 0; c < 400; c++) begin
         int r, sz;
         logic [63:0] w;
         @(negedge clk);
         if (bus.tx_start) starts++;
         total++;
         if (int'(bus.count) != acc - starts) begin
            bad++;
            $display("FAIL b2b_count cycle=%0d got=%0d required=%0d", c, bus.count, acc - starts);
         end
         bus.wr_en = 1'b0; bus.word_en = 1'b0;
         bfm_delay = $urandom_range(0, 3);
         bfm_len   = $urandom_range(1, 5);
         r  = $urandom_range(0, 9);
         sz = (r < 5) ? 1 : (r < 7) ? 8 : 0;
         if (sz != 0 && acc - (done_cnt - d0) + sz <= DEPTH) begin
            if (sz == 1) begin
               bus.wr_en = 1'b1; bus.wr_data = 8'($urandom);
               exp_q.push_back(bus.wr_data);
            end else begin
               w = {$urandom, $urandom};
               bus.word_en = 1'b1; bus.word_data = w;
               push_word(w);
            end
            acc += sz;
         end
      end
      drive_idle();
      wait_drain("b2b", 2000);
      total += 3;
      if (n_start - s0 != acc)   begin bad++; $display("FAIL b2b_sent got=%0d required=%0d", n_start - s0, acc); end
      if (bus.overflow !== 1'b0) begin bad++; $display("FAIL b2b_overflow got=%b required=0", bus.overflow); end
      if (bus.tx_err !== 1'b0)   begin bad++; $display("FAIL b2b_tx_err got=%b required=0", bus.tx_err); end
   endtask

   task automatic test_reset_mid();
      int s0;
      bfm_delay = 0; bfm_len = 30;
      set_mode(MODE_NORM);
      for (int i = 0; i < 6; i++) begin
         drive_byte(8'(8'h70 + i)); exp_q.push_back(8'(8'h70 + i));
      end
      drive_idle();
      @(negedge clk);
      total += 2;
      if (bus.count !== 5'd5)   begin bad++; $display("FAIL rmid_count got=%0d required=5", bus.count); end
      if (bus.tx_busy !== 1'b1) begin bad++; $display("FAIL rmid_busy got=%b required=1", bus.tx_busy); end
      rst_n = 1'b0;
      set_mode(MODE_LOW);
      #1;
      total += 7;
      if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL rmid_tx_data got=%h required=00", bus.tx_data); end
      if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL rmid_tx_start got=%b required=0", bus.tx_start); end
      if (bus.count !== '0)      begin bad++; $display("FAIL rmid_count0 got=%0d required=0", bus.count); end
      if (bus.empty !== 1'b1)    begin bad++; $display("FAIL rmid_empty got=%b required=1", bus.empty); end
      if (bus.full !== 1'b0)     begin bad++; $display("FAIL rmid_full got=%b required=0", bus.full); end
      if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rmid_overflow got=%b required=0", bus.overflow); end
      if (bus.tx_err !== 1'b0)   begin bad++; $display("FAIL rmid_tx_err got=%b required=0", bus.tx_err); end
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      set_mode(MODE_NORM);
      bfm_len = 3;
      s0 = n_start;
      repeat (20) @(negedge clk);
      total += 2;
      if (n_start != s0)       begin bad++; $display("FAIL rmid_no_start got=%0d required=0", n_start - s0); end
      if (bus.tx_err !== 1'b0) begin bad++; $display("FAIL rmid_err_after got=%b required=0", bus.tx_err); end
      drive_byte(8'h3C); exp_q.push_back(8'h3C);
      drive_idle();
      wait_drain("rmid", 100);
      total++;
      if (n_start - s0 != 1) begin bad++; $display("FAIL rmid_restart got=%0d required=1", n_start - s0); end
   endtask

   initial begin
      bus.clr = 1'b0; bus.wr_en = 1'b0; bus.wr_data = 8'h00;
      bus.word_en = 1'b0; bus.word_data = 64'h0; bus.tx_busy = 1'b0;
      test_reset();
      test_single_byte();
      test_word();
      test_both_en();
      test_timeout();
      test_clr();
      test_full();
      test_word_reject();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes; power of two, minimum 8.
REQ-002 Parameter TIMEOUT, default 4096, clk cycles allowed between tx_start and tx_busy rising.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 clr  input  1  synchronous flush, active-high.
REQ-006 wr_en  input  1  push wr_data this cycle.
REQ-007 wr_data  input  8  byte to queue.
REQ-008 word_en  input  1  push word_data as 8 bytes, LSB byte first.
REQ-009 word_data  input  64  word to queue.
REQ-010 tx_busy  input  1  transmitter status, high while a frame is on the line.
REQ-011 tx_data  output  8  registered byte presented to the transmitter.
REQ-012 tx_start  output  1  one-cycle pulse; tx_data is valid on the same cycle.
REQ-013 count  output  $clog2(DEPTH)+1  bytes currently queued.
REQ-014 full / empty  output  1 each  count==DEPTH / count==0, both derived from registered count.
REQ-015 overflow  output  1  sticky; a write was rejected.
REQ-016 tx_err  output  1  sticky; transmitter failed to assert busy within TIMEOUT.

Function
REQ-017 Storage shall be a circular buffer with wrapping write and read pointers; count shall be tracked explicitly.
REQ-018 A byte write while full shall be dropped and shall set overflow, even if a pop occurs in the same cycle.
REQ-019 A word write shall be accepted only if count <= DEPTH-8; it shall then add 8 to count in one cycle, storing word_data[7:0] first and word_data[63:56] last.
REQ-020 A word write with fewer than 8 free slots shall be rejected whole, with no partial write, and shall set overflow.
REQ-021 If wr_en and word_en are both high, word_en shall take priority, the byte shall be dropped, and overflow shall be set.
REQ-022 A write and a pop in the same cycle shall both take effect; count shall change by writes minus 1.
REQ-023 The FSM shall have states IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-024 In IDLE with !empty, the FSM shall pop the head into tx_data and go to START.
REQ-025 In START, tx_start shall be high for exactly one cycle, the timeout timer shall clear, and the FSM shall go to WAIT_BUSY.
REQ-026 In WAIT_BUSY, tx_busy==1 shall go to WAIT_DONE; when the timer reaches TIMEOUT-1, tx_err shall set, the byte shall be discarded, and the FSM shall go to IDLE.
REQ-027 In WAIT_DONE, tx_busy==0 shall go to IDLE; the next pop may occur on that same IDLE cycle.
REQ-028 Latency: a byte written into an empty FIFO with the FSM in IDLE at cycle N shall produce a tx_start pulse at cycle N+2.
REQ-029 tx_data shall hold its value until the next pop.
REQ-030 No pop shall occur outside IDLE.
REQ-031 The timeout timer shall be wide enough for TIMEOUT and shall saturate, not wrap.
REQ-032 clr shall set pointers and count to 0, set the state to IDLE, set tx_start to 0, and clear overflow and tx_err.
REQ-033 clr shall override any write in the same cycle.
REQ-034 tx_data shall be unchanged by clr.

Reset
REQ-035 When rst_n is low, all state shall reset immediately: pointers=0, count=0, state=IDLE, tx_data=8'h00, tx_start=0, overflow=0, tx_err=0, empty=1, full=0.
REQ-036 Reset asserted mid-frame shall abandon the byte in flight without raising tx_err.
REQ-037 Release of rst_n shall be synchronised externally; the first active edge after release shall be a normal cycle.

Verification
REQ-038 Single byte: write 8'hA5 at cycle N, model busy high for 10 cycles from N+3 -> tx_start at N+2 with tx_data=8'hA5, count returns to 0, and exactly one pulse occurs.
REQ-039 Word: word_en with 64'h1122334455667788 -> tx_data sequence 88,77,66,55,44,33,22,11, one tx_start per busy-low interval, overflow=0.
REQ-040 Full boundary: DEPTH byte writes with tx_busy held high, then one more write -> full=1, overflow=1, count==DEPTH, and the extra byte never transmitted.
REQ-041 Word reject: count=DEPTH-7, then word_en -> count unchanged, overflow=1, and queued bytes still sent in order.
REQ-042 Timeout: tx_busy tied low and one byte written -> tx_err=1 exactly TIMEOUT cycles after tx_start, FSM back in IDLE, and the next byte is attempted.
REQ-043 Reset mid-operation: assert rst_n low during WAIT_DONE with 5 bytes queued -> all outputs at reset values immediately, and no tx_start after release until a new write.
